ex_div: RTL and testbench

Iterative RV32M divider in the EX stage. Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. It sits directly upstream of the pipeline controller and drives the controller's EX stall request, freezing PC, IF, ID and EX while a division runs. It also consumes the controller's flush so a killed instruction abandons its division.

---
 rtl/ex_div.sv | 173 +++++++++++++++++
 tb/tb_ex_div.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider (DIV/DIVU/REM/REMU) in the EX stage.
// Radix-2 restoring divider, one quotient bit per cycle, 32 iterations.
// Drives the EX stall request and abandons its division on flush_i.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// finish one cycle after issue instead of running all 32 iterations.
module ex_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic [31:0] result_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        in_signed;
    logic        in_dvd_neg;
    logic        in_dsr_neg;
    logic        in_div0;
    logic        in_ovf;
    logic [32:0] shifted;
    logic        qbit;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    // Operand conditioning, one restoring step, and final sign/special-case fix-up
    always_comb begin
        in_signed  = ~op_i[0];
        in_dvd_neg = in_signed & dividend_i[31];
        in_dsr_neg = in_signed & divisor_i[31];
        in_div0    = (divisor_i == '0);
        in_ovf     = in_signed & (dividend_i == 32'h8000_0000) & (divisor_i == '1);

        // Partial remainder is compared at 33 bits so divisors >= 2^31 keep the
        // bit shifted out of rem; the difference itself always fits in 32 bits.
        shifted = {rem_q, dvd_q[31]};
        qbit    = (shifted >= {1'b0, dsr_q});
        rem_nx  = qbit ? (shifted[31:0] - dsr_q) : shifted[31:0];
        quo_nx  = {dvd_q[30:0], qbit};

        quo_fin = qneg_q ? (32'd0 - quo_nx) : quo_nx;
        rem_fin = rneg_q ? (32'd0 - rem_nx) : rem_nx;
        if (div0_q) begin
            quo_fin = '1;
        end
        if (ovf_q) begin
            quo_fin = 32'h8000_0000;
            rem_fin = '0;
        end

        state_d  = state_q;
        op_d     = op_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    dvd_d   = in_dvd_neg ? (32'd0 - dividend_i) : dividend_i;
                    dsr_d   = in_dsr_neg ? (32'd0 - divisor_i) : divisor_i;
                    qneg_d  = in_dvd_neg ^ in_dsr_neg;
                    rneg_d  = in_dvd_neg;
                    div0_d  = in_div0;
                    ovf_d   = in_ovf;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        if (in_div0) begin
                            result_d = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
                        end else begin
                            result_d = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                        end
                    end
`endif
                end
            end
            S_CALC: begin
                // A dropped start_i means the instruction left EX: abandon like a flush
                if (flush_i || !start_i) begin
                    state_d = S_IDLE;
                end else begin
                    dvd_d = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = op_q[1] ? rem_fin : quo_fin;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result_o   = result_q;
    assign done_o     = done_q;
    assign stallreq_o = start_i & ~done_q & ~flush_i;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [31:0] result_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif
    localparam int NRM_LAT = 33;

    ex_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .result_o   (result_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one divide from the current time (cycle 0) and follow it to done_o.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int exp_lat, input bit keep, output int done_cyc);
        int  n;
        int  stalls;
        bit  seen;
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        n          = 0;
        stalls     = 0;
        seen       = 1'b0;
        done_cyc   = 0;
        while (n < 100) begin
            #1;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (stallreq_o) stalls++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!seen) begin
            start_i = 1'b0;
            return;
        end
        done_cyc = cyc;
        chk({tag, "_res"}, result_o, exp_res);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_stall_cycles"}, stalls, exp_lat);
        chk({tag, "_stall_in_done"}, 32'(stallreq_o), 32'd0);
        if (!keep) begin
            start_i = 1'b0;
            @(negedge clk);
            #1;
            chk({tag, "_strobe"}, 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        int c1;
        int c2;
        bit any_done;

        rst_n      = 1'b0;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_stall_lo", 32'(stallreq_o), 32'd0);
        start_i = 1'b1;
        #1;
        chk("rst_stall_follow", 32'(stallreq_o), 32'd1);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E, NRM_LAT, 1'b0, c1);
        run_div("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002, NRM_LAT, 1'b0, c1);
        run_div("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NRM_LAT, 1'b0, c1);
        run_div("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NRM_LAT, 1'b0, c1);
        run_div("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, NRM_LAT, 1'b0, c1);
        run_div("divu_z",     2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SP_LAT, 1'b0, c1);
        run_div("remu_z",     2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, SP_LAT, 1'b0, c1);
        run_div("div_neg_z",  2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SP_LAT, 1'b0, c1);
        run_div("rem_neg_z",  2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SP_LAT, 1'b0, c1);
        run_div("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT, 1'b0, c1);
        run_div("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SP_LAT, 1'b0, c1);
        run_div("divu_big",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, NRM_LAT, 1'b0, c1);
        run_div("remu_big",   2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, NRM_LAT, 1'b0, c1);

        // flush at cycle 10 of a DIVU, with start_i still high
        start_i    = 1'b1;
        op_i       = 2'b01;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(stallreq_o), 32'd0);
        chk("flush_done", 32'(done_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("flush_after_stall", 32'(stallreq_o), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) any_done = 1'b1;
        end
        chk("flush_no_done", 32'(any_done), 32'd0);
        chk("flush_result_kept", result_o, 32'h7FFF_FFFE);
        run_div("post_flush", 2'b01, 32'd100, 32'd7, 32'h0000_000E, NRM_LAT, 1'b0, c1);

        // reset at cycle 15 of a divide
        start_i    = 1'b1;
        op_i       = 2'b01;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", result_o, 32'h0);
        chk("midrst_stall", 32'(stallreq_o), 32'd1);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("b2b_divu_9_3", 2'b01, 32'd9, 32'd3, 32'h0000_0003, NRM_LAT, 1'b1, c1);
        @(negedge clk);
        run_div("b2b_remu_10_4", 2'b11, 32'd10, 32'd4, 32'h0000_0002, NRM_LAT, 1'b0, c2);
        chk("b2b_gap", c2 - c1, 32'd34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
